// File: rtl/dadda_mac_accum.sv
// Frame accumulator behind the 8x8 Dadda multiplier.
// Sums FRAME_LEN unsigned 17-bit products into a saturating accumulator.
// Each frame total is presented on a registered valid/ready output.
// Product intake stalls while a finished frame has nowhere to go.
module dadda_mac_accum #(
  parameter  int FRAME_LEN = 8,
  parameter  int ACC_W     = 24,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16:0]      RES_IN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] ACC_OUT,
  output logic             OVF,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  // Frame-in-progress state
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;

  // Single-entry output register
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc_out;
  logic             r_ovf;

  logic             w_last;
  logic             w_accept;
  logic             w_complete;
  logic [ACC_W:0]   w_sum;
  logic             w_sum_ovf;
  logic [ACC_W-1:0] w_sat;

  assign w_last = (r_cnt == LAST_IDX);

  // A product that would finish a frame is held off while the previous
  // result is still unclaimed; a consumer drain this cycle frees the slot.
  assign in_ready   = !flush && !(w_last && r_out_valid && !out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && w_last;

  // One extra bit so a carry out of the accumulator is visible.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 16){1'b0}}, RES_IN};
  assign w_sum_ovf = w_sum[ACC_W];

  // Clamp the sum to all-ones on carry-out.
  always_comb begin
    // NOTE: default first so every path assigns w_sat and no latch is inferred.
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum_ovf) begin
      w_sat = '1;
    end
  end

  // Accumulate accepted products; flush or frame completion restarts the frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (flush) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_sticky <= 1'b0;
      end else begin
        r_acc    <= w_sat;
        r_cnt    <= r_cnt + CNT_W'(1);
        r_sticky <= r_sticky | w_sum_ovf;
      end
    end
  end

  // Output register: load on frame completion, clear on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
      r_ovf       <= 1'b0;
    end else if (w_complete) begin
      r_out_valid <= 1'b1;
      r_acc_out   <= w_sat;
      r_ovf       <= r_sticky | w_sum_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ACC_OUT   = r_acc_out;
  assign OVF       = r_ovf;
  assign CNT       = r_cnt;

endmodule

// File: tb/tb_dadda_mac_accum.sv
// Self-checking bench for dadda_mac_accum.
// Three instances share one stimulus stream:
//   u0 FRAME_LEN=4 ACC_W=24, u1 FRAME_LEN=4 ACC_W=18, u2 FRAME_LEN=1 ACC_W=24.
// A frame-level reference model keeps the unbounded integer frame total and
// clamps it only when the frame closes.
module tb_dadda_mac_accum;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [16:0] res_in;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic        ovf0, ovf1, ovf2;
  logic [23:0] acc0;
  logic [17:0] acc1;
  logic [23:0] acc2;
  logic [2:0]  cnt0, cnt1;
  logic [0:0]  cnt2;

  dadda_mac_accum #(.FRAME_LEN(4), .ACC_W(24)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .RES_IN(res_in), .out_valid(vld0), .out_ready(out_ready),
    .ACC_OUT(acc0), .OVF(ovf0), .CNT(cnt0)
  );

  dadda_mac_accum #(.FRAME_LEN(4), .ACC_W(18)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .RES_IN(res_in), .out_valid(vld1), .out_ready(out_ready),
    .ACC_OUT(acc1), .OVF(ovf1), .CNT(cnt1)
  );

  dadda_mac_accum #(.FRAME_LEN(1), .ACC_W(24)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .RES_IN(res_in), .out_valid(vld2), .out_ready(out_ready),
    .ACC_OUT(acc2), .OVF(ovf2), .CNT(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance-indexed views of the DUT outputs
  logic        o_rdy [3];
  logic        o_vld [3];
  logic        o_ovf [3];
  logic [63:0] o_acc [3];
  logic [63:0] o_cnt [3];

  assign o_rdy[0] = rdy0;  assign o_rdy[1] = rdy1;  assign o_rdy[2] = rdy2;
  assign o_vld[0] = vld0;  assign o_vld[1] = vld1;  assign o_vld[2] = vld2;
  assign o_ovf[0] = ovf0;  assign o_ovf[1] = ovf1;  assign o_ovf[2] = ovf2;
  assign o_acc[0] = 64'(acc0); assign o_acc[1] = 64'(acc1); assign o_acc[2] = 64'(acc2);
  assign o_cnt[0] = 64'(cnt0); assign o_cnt[1] = 64'(cnt1); assign o_cnt[2] = 64'(cnt2);

  localparam int     FL   [3] = '{4, 4, 1};
  localparam longint MAXV [3] = '{64'hFF_FFFF, 64'h3_FFFF, 64'hFF_FFFF};

  // Reference model: products taken so far in the frame, their plain sum,
  // and the one result slot.
  int     m_cnt  [3];
  longint m_tot  [3];
  bit     m_pend [3];
  longint m_acc  [3];
  bit     m_ovf  [3];
  bit     m_take [3];
  bit     m_rdy  [3];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare all instances against the model at the falling edge, then advance
  // the model across the next rising edge. Returns #1 after that edge.
  task automatic tick();
    bit done;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      // Refuse a product when flushing, or when it would close a frame while
      // the previous result is still waiting and not being taken now.
      m_rdy[k] = !flush && !((m_cnt[k] + 1 == FL[k]) && m_pend[k] && !out_ready);
      check($sformatf("in_ready[u%0d]", k),  64'(o_rdy[k]), 64'(m_rdy[k]));
      check($sformatf("out_valid[u%0d]", k), 64'(o_vld[k]), 64'(m_pend[k]));
      check($sformatf("ACC_OUT[u%0d]", k),   o_acc[k],      64'(m_acc[k]));
      check($sformatf("OVF[u%0d]", k),       64'(o_ovf[k]), 64'(m_ovf[k]));
      check($sformatf("CNT[u%0d]", k),       o_cnt[k],      64'(m_cnt[k]));
    end
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_tot[k] = 0; m_pend[k] = 0;
        m_acc[k] = 0; m_ovf[k] = 0; m_take[k] = 0;
      end else begin
        done      = 0;
        m_take[k] = in_valid && m_rdy[k];
        if (flush) begin
          m_cnt[k] = 0;
          m_tot[k] = 0;
        end else if (m_take[k]) begin
          m_tot[k] += longint'(res_in);
          m_cnt[k]++;
          if (m_cnt[k] == FL[k]) begin
            done     = 1;
            m_ovf[k] = (m_tot[k] > MAXV[k]);
            m_acc[k] = m_ovf[k] ? MAXV[k] : m_tot[k];
            m_cnt[k] = 0;
            m_tot[k] = 0;
          end
        end
        if (done) m_pend[k] = 1;
        else if (out_ready) m_pend[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one product until u0 takes it, with a bounded wait.
  task automatic send(input int v);
    int n;
    n = 0;
    in_valid = 1'b1;
    res_in   = 17'(v);
    do begin
      tick();
      n++;
    end while (!m_take[0] && n < 50);
    if (!m_take[0]) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed=not_accepted expected=accepted value=%0d", v);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_tot[k] = 0; m_pend[k] = 0;
      m_acc[k] = 0; m_ovf[k] = 0; m_take[k] = 0; m_rdy[k] = 0;
    end
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; res_in = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_cnt",  64'(cnt0), 64'd0);
    check("reset_acc",  64'(acc0), 64'd0);
    check("reset_vld",  64'(vld0), 64'd0);

    // Basic frame of four products
    send(10); check("t1_cnt1", 64'(cnt0), 64'd1);
    send(20); check("t1_cnt2", 64'(cnt0), 64'd2);
    send(30); check("t1_cnt3", 64'(cnt0), 64'd3);
    send(40); check("t1_cnt0", 64'(cnt0), 64'd0);
    check("t1_vld", 64'(vld0), 64'd1);
    check("t1_acc", 64'(acc0), 64'd100);
    check("t1_ovf", 64'(ovf0), 64'd0);
    tick();
    check("t1_vld_drop", 64'(vld0), 64'd0);

    // Backpressure: result 10 stays parked, fourth 5 is held off
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    send(5); send(5); send(5);
    check("t2_hold_acc", 64'(acc0), 64'd10);
    in_valid = 1'b1; res_in = 17'd5;
    #1;
    check("t2_stall_rdy", 64'(rdy0), 64'd0);
    tick();
    check("t2_stall_rdy2", 64'(rdy0), 64'd0);
    check("t2_stall_acc",  64'(acc0), 64'd10);
    out_ready = 1'b1;
    #1;
    check("t2_release_rdy", 64'(rdy0), 64'd1);
    tick();
    in_valid = 1'b0;
    check("t2_new_vld", 64'(vld0), 64'd1);
    check("t2_new_acc", 64'(acc0), 64'd20);
    tick();

    // Saturation on the 18-bit instance, then a clean frame
    send(131071); send(131071); send(131071); send(1);
    check("t3_sat_acc", 64'(acc1), 64'd262143);
    check("t3_sat_ovf", 64'(ovf1), 64'd1);
    check("t3_wide_acc", 64'(acc0), 64'd393214);
    send(1); send(1); send(1); send(1);
    check("t3_clean_acc", 64'(acc1), 64'd4);
    check("t3_clean_ovf", 64'(ovf1), 64'd0);

    // Flush discards a partial frame and refuses the coincident product
    send(7); send(7);
    flush = 1'b1; in_valid = 1'b1; res_in = 17'd99;
    #1;
    check("t4_flush_rdy", 64'(rdy0), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_flush_cnt", 64'(cnt0), 64'd0);
    send(5); send(5); send(5); send(5);
    check("t4_acc", 64'(acc0), 64'd20);

    // Reset mid-frame, then reset with a result pending
    send(1); send(1); send(1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_cnt", 64'(cnt0), 64'd0);
    check("t5_vld", 64'(vld0), 64'd0);
    check("t5_acc", 64'(acc0), 64'd0);
    out_ready = 1'b0;
    send(1); send(2); send(3); send(4);
    check("t5_acc10", 64'(acc0), 64'd10);
    tick();
    check("t5_pend_vld", 64'(vld0), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_pend_clr", 64'(vld0), 64'd0);
    out_ready = 1'b1;

    // Single-product frames on u2
    send(131071);
    check("t6_acc_a", 64'(acc2), 64'd131071);
    check("t6_vld_a", 64'(vld2), 64'd1);
    check("t6_rdy_a", 64'(rdy2), 64'd1);
    send(0);
    check("t6_acc_b", 64'(acc2), 64'd0);
    check("t6_vld_b", 64'(vld2), 64'd1);
    send(65025);
    check("t6_acc_c", 64'(acc2), 64'd65025);
    check("t6_vld_c", 64'(vld2), 64'd1);
    check("t6_cnt",   64'(cnt2), 64'd0);
    tick();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       res_in = 17'h1FFFF;
        1:       res_in = 17'h0;
        default: res_in = 17'($urandom);
      endcase
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dadda_mac_accum.md
Name: dadda_mac_accum

Overview:
- Sequential accumulator directly downstream of the combinational 8x8 Dadda multiplier top level; consumes its 17-bit RES product word.
- Sums FRAME_LEN accepted products into a saturating accumulator.
- Presents each frame total on a registered valid/ready output.
- Back-pressures the product source when a finished frame cannot be delivered.

Parameters:
- FRAME_LEN, 8, products per frame; legal range >=1.
- ACC_W, 24, accumulator/result width; legal range >=17.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards the partial frame.
- in_valid  input  1  RES_IN holds a product.
- in_ready  output  1  block accepts a product this cycle.
- RES_IN  input  17  product word from multiplier RES; unsigned.
- out_valid  output  1  ACC_OUT/OVF hold a frame result.
- out_ready  input  1  consumer takes the result.
- ACC_OUT  output  ACC_W  frame sum.
- OVF  output  1  frame saturated.
- CNT  output  $clog2(FRAME_LEN+1)  products accumulated in the current frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Clears acc, CNT, the sticky overflow, out_valid, ACC_OUT and OVF to 0.
  - Reset overrides every other input. Reset mid-frame drops both the partial frame and any pending result.
- Accept: a product is accepted when in_valid && in_ready. Only accepted products affect state.
- in_ready is combinational: !flush && !(CNT==FRAME_LEN-1 && out_valid && !out_ready). The path out_ready->in_ready is intentional.
- Arithmetic:
  - sum = acc + zero-extend(RES_IN), computed at ACC_W+1 bits.
  - If sum > 2^ACC_W-1, the result saturates to all-ones and the sticky overflow is set.
  - Once acc is saturated it stays saturated until the frame ends.
- Non-last accept (CNT < FRAME_LEN-1): acc<=sat(sum); CNT<=CNT+1.
- Last accept (CNT == FRAME_LEN-1):
  - ACC_OUT<=sat(sum); OVF<=sticky|overflow(sum); out_valid<=1.
  - acc<=0; CNT<=0; sticky<=0.
  - Latency: out_valid is high the cycle after the last product is accepted.
- Output handshake:
  - ACC_OUT and OVF are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, out_valid clears, unless a last accept occurs in the same cycle. In that case the new result loads and out_valid stays 1.
- Flush:
  - Clears acc, CNT and sticky next cycle.
  - in_ready=0 while flush is high, so a simultaneous in_valid product is not accepted.
  - A pending output result is unaffected, and the output handshake continues normally during flush.
- FRAME_LEN=1: every accepted product is a frame. CNT is constantly 0.
- Wrap-around: CNT returns to 0 after each frame. There is no gap cycle between frames.
- No internal storage beyond the single output register. A frame can complete only when the output register is empty or being drained that cycle.

Test Plan:
- FRAME_LEN=4, out_ready=1, products 10,20,30,40 on consecutive cycles -> one cycle after the 40 is accepted: out_valid=1, ACC_OUT=100, OVF=0 for one cycle; CNT sequence 0,1,2,3,0.
- Backpressure, FRAME_LEN=4, out_ready=0:
  - Frame 1,2,3,4 -> ACC_OUT=10 held; next frame 5,5,5 accepted.
  - 4th product (5): in_ready=0 and the product is held.
  - Raise out_ready -> 10 consumed; the product is accepted in the same cycle; next cycle ACC_OUT=20 with out_valid=1 continuous.
- Saturation, ACC_W=18, FRAME_LEN=4, products 131071,131071,131071,1 -> ACC_OUT=262143, OVF=1; next frame 1,1,1,1 -> ACC_OUT=4, OVF=0.
- Flush, FRAME_LEN=4:
  - Accept 7,7; then flush=1 with in_valid=1, RES_IN=99 -> in_ready=0 and 99 is not accepted; CNT=0 next cycle.
  - Then 5,5,5,5 -> ACC_OUT=20.
- Reset mid-operation, FRAME_LEN=4:
  - Accept 3 products, pulse rst -> CNT=0, out_valid=0, ACC_OUT=0.
  - Then 1,2,3,4 -> ACC_OUT=10.
  - Also apply rst while a result is pending -> out_valid=0 next cycle.
- FRAME_LEN=1, out_ready=1, stream 131071,0,65025 -> ACC_OUT 131071,0,65025 on consecutive cycles; out_valid held 1; in_ready constantly 1.
